// File: rtl/clk_gate_pkg.sv
// Package: clk_gate_pkg
// Purpose : shared types and defaults for the CPU clock gate slice.
//   run_mode_t   - encoding of the mode_in selector (HALT/STEP/SLOW/FULL)
//   gate_state_t - state of the gating FSM inside cpu_clock_gate
//   mode_to_state- maps a requested run mode onto the FSM state that serves it
package clk_gate_pkg;

  typedef enum logic [1:0] {
    HALT = 2'b00,
    STEP = 2'b01,
    SLOW = 2'b10,
    FULL = 2'b11
  } run_mode_t;

  typedef enum logic [1:0] {
    S_HALT = 2'b00,
    S_STEP = 2'b01,
    S_SLOW = 2'b10,
    S_FULL = 2'b11
  } gate_state_t;

  localparam int unsigned DEBOUNCE_CYCLES_DEFAULT = 32'd1000000;
  localparam int unsigned CNT_W_DEFAULT           = 32;

  function automatic gate_state_t mode_to_state(input run_mode_t mode);
    gate_state_t st;
    case (mode)
      HALT:    st = S_HALT;
      STEP:    st = S_STEP;
      SLOW:    st = S_SLOW;
      FULL:    st = S_FULL;
      default: st = S_HALT;
    endcase
    return st;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Module : btn_debounce
// Purpose: brings a raw, bouncy, asynchronous push-button into the clk_in domain and
//          accepts a new level only after it has been stable for DEBOUNCE_CYCLES cycles.
// Ports  :
//   clk_in    in  1  system clock
//   rst_n     in  1  asynchronous active-low reset
//   raw_in    in  1  raw button level (active high, asynchronous)
//   level_out out 1  debounced button level
//   rise_out  out 1  one-cycle pulse, registered together with a 0->1 change of level_out
module btn_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 1000000
) (
  input  logic clk_in,
  input  logic rst_n,
  input  logic raw_in,
  output logic level_out,
  output logic rise_out
);

  localparam int unsigned CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1_q, sync2_q;
  logic          level_q, level_d;
  logic          rise_q, rise_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // The counter only advances while the synchronised input disagrees with the accepted
  // level; a single agreeing sample drops it back to zero, so only an unbroken run of
  // DEBOUNCE_CYCLES disagreeing samples flips the level.
  always_comb begin
    cnt_d   = '0;
    level_d = level_q;
    rise_d  = 1'b0;
    if (sync2_q != level_q) begin
      if (cnt_q == LAST) begin
        level_d = sync2_q;
        rise_d  = sync2_q;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      level_q <= 1'b0;
      rise_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= raw_in;
      sync2_q <= sync1_q;
      level_q <= level_d;
      rise_q  <= rise_d;
      cnt_q   <= cnt_d;
    end
  end

  assign level_out = level_q;
  assign rise_out  = rise_q;

endmodule

// File: rtl/cpu_clock_gate.sv
// Module : cpu_clock_gate
// Purpose: turns the divided slow clock and a debounced step button into a CPU
//          clock-enable stream (halt / single-step / slow-run / full-run), counts issued
//          CPU cycles and latches a sticky stop when the CPU reports a breakpoint.
// Ports  :
//   clk_in        in  1      system clock, all logic on posedge
//   rst_n         in  1      asynchronous active-low reset
//   slow_clk_in   in  1      divided clock level (already in clk_in domain)
//   step_btn_in   in  1      raw step push-button, active high
//   mode_in       in  2      run mode: 00 HALT, 01 STEP, 10 SLOW, 11 FULL
//   brk_in        in  1      breakpoint hit, meaningful only while cpu_en_out=1
//   cnt_clr_in    in  1      synchronous clear of cycle_cnt_out
//   cpu_en_out    out 1      CPU clock enable
//   cycle_cnt_out out CNT_W  enabled cycles since reset/clear (wraps)
//   stopped_out   out 1      sticky breakpoint stop flag
module cpu_clock_gate
  import clk_gate_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
  parameter int unsigned CNT_W           = CNT_W_DEFAULT
) (
  input  logic             clk_in,
  input  logic             rst_n,
  input  logic             slow_clk_in,
  input  logic             step_btn_in,
  input  logic [1:0]       mode_in,
  input  logic             brk_in,
  input  logic             cnt_clr_in,
  output logic             cpu_en_out,
  output logic [CNT_W-1:0] cycle_cnt_out,
  output logic             stopped_out
);

  gate_state_t      state_q, state_d;
  logic             cpu_en_q, cpu_en_d;
  logic             stopped_q, stopped_d;
  logic             slow_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             btn_level, btn_rise;
  logic             step_req, slow_rise, switching;

  btn_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_btn_debounce (
    .clk_in   (clk_in),
    .rst_n    (rst_n),
    .raw_in   (step_btn_in),
    .level_out(btn_level),
    .rise_out (btn_rise)
  );

  // Rise and level are registered together; qualifying with the level ties every
  // request to an accepted high button state.
  assign step_req  = btn_rise & btn_level;
  assign slow_rise = slow_clk_in & ~slow_q;

  // Next state simply follows the requested mode. While the state is changing no
  // enable is issued, so a mode switch never produces a pulse of either mode.
  // The stop flag is computed first because SLOW/FULL gate on its next value: that way
  // the enable drops in the very cycle the breakpoint is seen, never one cycle late.
  always_comb begin
    state_d   = mode_to_state(run_mode_t'(mode_in));
    switching = (state_d != state_q);

    stopped_d = stopped_q;
    if (switching && ((state_d == S_HALT) || (state_d == S_STEP))) begin
      stopped_d = 1'b0;
    end else if (cpu_en_q && brk_in) begin
      stopped_d = 1'b1;
    end

    cpu_en_d = 1'b0;
    if (!switching) begin
      case (state_q)
        S_HALT:  cpu_en_d = 1'b0;
        S_STEP:  cpu_en_d = step_req;
        S_SLOW:  cpu_en_d = slow_rise & ~stopped_d;
        S_FULL:  cpu_en_d = ~stopped_d;
        default: cpu_en_d = 1'b0;
      endcase
    end

    cnt_d = cnt_q;
    if (cnt_clr_in) begin
      cnt_d = '0;
    end else if (cpu_en_q) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_HALT;
      cpu_en_q  <= 1'b0;
      stopped_q <= 1'b0;
      slow_q    <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      cpu_en_q  <= cpu_en_d;
      stopped_q <= stopped_d;
      slow_q    <= slow_clk_in;
      cnt_q     <= cnt_d;
    end
  end

  assign cpu_en_out    = cpu_en_q;
  assign cycle_cnt_out = cnt_q;
  assign stopped_out   = stopped_q;

endmodule
